// File: rtl/alu_pkg.sv
// Shared ALU opcodes, arbiter state encoding and the opcode legality check.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_OR) || (op == ALU_AND);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: unsigned modulo-2^WIDTH add/sub plus bitwise or/and.
// Unknown opcodes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] result
);

  // Opcode decode; default covers the illegal codes.
  always_comb begin
    result = '0;
    case (opcode)
      ALU_ADD: result = left + right;
      ALU_SUB: result = left - right;
      ALU_OR:  result = left | right;
      ALU_AND: result = left & right;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between the execute (port 0) and AGU (port 1)
// requesters. One operation in flight; the result is held until its owner
// consumes it, and a new op may be accepted in the same cycle as that consume.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_opcode,
  input  logic [WIDTH-1:0] req0_left,
  input  logic [WIDTH-1:0] req0_right,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_opcode,
  input  logic [WIDTH-1:0] req1_left,
  input  logic [WIDTH-1:0] req1_right,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_illegal,
  output logic [15:0]      op_count
);

  state_t           state, state_nxt;
  logic             owner;
  logic             last_grant;
  logic             consume;
  logic             can_grant;
  logic             gnt0, gnt1;
  logic             accept;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_l, alu_r, alu_res;

  // The owner's consume frees the slot in the same cycle, giving full throughput.
  assign consume   = (state == HOLD) && (owner ? resp1_ready : resp0_ready);
  assign can_grant = (state == IDLE) || consume;

  // On a tie, the port that did not win last time goes next.
  assign gnt0   = can_grant && req0_valid && (!req1_valid || last_grant);
  assign gnt1   = can_grant && req1_valid && (!req0_valid || !last_grant);
  assign accept = gnt0 || gnt1;

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign resp0_valid = (state == HOLD) && !owner;
  assign resp1_valid = (state == HOLD) && owner;

  assign alu_op = gnt1 ? req1_opcode : req0_opcode;
  assign alu_l  = gnt1 ? req1_left   : req0_left;
  assign alu_r  = gnt1 ? req1_right  : req0_right;

  alu #(.WIDTH(WIDTH)) u_alu (
    .opcode (alu_op),
    .left   (alu_l),
    .right  (alu_r),
    .result (alu_res)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: an accept always (re)fills the slot; a bare consume empties it.
  always_comb begin
    state_nxt = state;
    if (accept)       state_nxt = HOLD;
    else if (consume) state_nxt = IDLE;
  end

  // Capture result, legality and ownership on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_result  <= '0;
      resp_illegal <= 1'b0;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
    end else if (accept) begin
      resp_result  <= alu_res;
      resp_illegal <= !op_legal(alu_op);
      owner        <= gnt1;
      last_grant   <= gnt1;
    end
  end

  // Completed-response counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          op_count <= '0;
    else if (consume) op_count <= op_count + 16'd1;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a per-cycle scoreboard (expected responses queued at
// accept, compared while held and popped on consume), a table of vectors, and
// hand-written sequences for tie, backpressure, async reset and counter wrap.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_opcode, req1_opcode;
  logic [W-1:0] req0_left, req0_right, req1_left, req1_right;
  logic         resp0_valid, resp1_valid;
  logic         resp0_ready, resp1_ready;
  logic [W-1:0] resp_result;
  logic         resp_illegal;
  logic [15:0]  op_count;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_opcode  (req0_opcode),
    .req0_left    (req0_left),
    .req0_right   (req0_right),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_opcode  (req1_opcode),
    .req1_left    (req1_left),
    .req1_right   (req1_right),
    .resp0_valid  (resp0_valid),
    .resp0_ready  (resp0_ready),
    .resp1_valid  (resp1_valid),
    .resp1_ready  (resp1_ready),
    .resp_result  (resp_result),
    .resp_illegal (resp_illegal),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         port;
    logic [W-1:0] res;
    logic         ill;
  } exp_t;

  typedef struct {
    logic         port;
    logic [2:0]   op;
    logic [W-1:0] l;
    logic [W-1:0] r;
    logic [W-1:0] res;
    logic         ill;
  } vec_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic        lg;
  logic [15:0] exp_cnt;
  logic        g0, g1;

  function automatic logic [W-1:0] model_res(input logic [2:0] op, input logic [W-1:0] l, input logic [W-1:0] r);
    case (op)
      3'b000:  return l + r;
      3'b100:  return l - r;
      3'b110:  return l | r;
      3'b111:  return l & r;
      default: return '0;
    endcase
  endfunction

  function automatic logic model_ill(input logic [2:0] op);
    return !(op == 3'b000 || op == 3'b100 || op == 3'b110 || op == 3'b111);
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare held outputs and grants at the falling edge, then
  // update the model for the consume/accept that the rising edge will take.
  task automatic step();
    logic ev0, ev1, cons, can, m0, m1;
    @(negedge clk);
    ev0 = (q.size() > 0) && (q[0].port == 1'b0);
    ev1 = (q.size() > 0) && (q[0].port == 1'b1);
    chk("resp0_valid", resp0_valid, ev0);
    chk("resp1_valid", resp1_valid, ev1);
    if (q.size() > 0) begin
      chk("resp_result", resp_result, q[0].res);
      chk("resp_illegal", resp_illegal, q[0].ill);
    end
    chk("op_count", op_count, exp_cnt);
    cons = (ev0 && resp0_ready) || (ev1 && resp1_ready);
    can  = (q.size() == 0) || cons;
    m0   = can && req0_valid && (!req1_valid || lg);
    m1   = can && req1_valid && (!req0_valid || !lg);
    chk("req0_ready", req0_ready, m0);
    chk("req1_ready", req1_ready, m1);
    if (cons) begin
      void'(q.pop_front());
      exp_cnt++;
    end
    if (m0) begin
      q.push_back('{1'b0, model_res(req0_opcode, req0_left, req0_right), model_ill(req0_opcode)});
      lg = 1'b0;
    end
    if (m1) begin
      q.push_back('{1'b1, model_res(req1_opcode, req1_left, req1_right), model_ill(req1_opcode)});
      lg = 1'b1;
    end
    g0 = m0;
    g1 = m1;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst resp0_valid", resp0_valid, 1'b0);
    chk("rst resp1_valid", resp1_valid, 1'b0);
    chk("rst resp_result", resp_result, '0);
    chk("rst resp_illegal", resp_illegal, 1'b0);
    chk("rst op_count", op_count, 16'd0);
    q.delete();
    lg = 1'b1;
    exp_cnt = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic issue(input logic port, input logic [2:0] op, input logic [W-1:0] l, input logic [W-1:0] r);
    logic acc;
    acc = 1'b0;
    if (!port) begin
      req0_opcode = op; req0_left = l; req0_right = r; req0_valid = 1'b1;
    end else begin
      req1_opcode = op; req1_left = l; req1_right = r; req1_valid = 1'b1;
    end
    for (int i = 0; i < 10 && !acc; i++) begin
      step();
      acc = port ? g1 : g0;
    end
    if (!port) req0_valid = 1'b0;
    else       req1_valid = 1'b0;
    if (!acc) chk("issue timeout", 1'b0, 1'b1);
  endtask

  vec_t vecs[8];
  int   gnt_log[4];

  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_opcode = 0; req1_opcode = 0;
    req0_left = 0; req0_right = 0; req1_left = 0; req1_right = 0;
    resp0_ready = 0; resp1_ready = 0;
    lg = 1'b1; exp_cnt = '0; g0 = 0; g1 = 0;
    #12;
    do_reset();

    // Single request: ADD 5+7 accepted at once, result next cycle.
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    req0_opcode = 3'b000; req0_left = 5; req0_right = 7; req0_valid = 1'b1;
    #1;
    chk("single req0_ready", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    chk("single resp0_valid", resp0_valid, 1'b1);
    chk("single result", resp_result, 32'd12);
    step();
    chk("single op_count", op_count, 16'd1);

    // Table of vectors, each issued alone with both ports ready to consume.
    vecs[0] = '{1'b0, 3'b000, 32'd5,        32'd7,        32'd12,        1'b0};
    vecs[1] = '{1'b1, 3'b100, 32'd0,        32'd1,        32'hFFFFFFFF,  1'b0};
    vecs[2] = '{1'b0, 3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,         1'b0};
    vecs[3] = '{1'b1, 3'b110, 32'h0F,       32'hF0,       32'hFF,        1'b0};
    vecs[4] = '{1'b0, 3'b111, 32'hF0,       32'h3C,       32'h30,        1'b0};
    vecs[5] = '{1'b1, 3'b001, 32'd5,        32'd3,        32'd0,         1'b1};
    vecs[6] = '{1'b0, 3'b010, 32'hAAAA,     32'h5555,     32'd0,         1'b1};
    vecs[7] = '{1'b1, 3'b100, 32'd10,       32'd3,        32'd7,         1'b0};
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].port, vecs[i].op, vecs[i].l, vecs[i].r);
      chk("vec result", resp_result, vecs[i].res);
      chk("vec illegal", resp_illegal, vecs[i].ill);
    end
    step();

    // Tie: both valid for 4 cycles, grants alternate starting with port 0.
    do_reset();
    req0_opcode = 3'b100; req0_left = 10;    req0_right = 3;
    req1_opcode = 3'b111; req1_left = 'hF0;  req1_right = 'h3C;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      gnt_log[i] = g0 ? 0 : (g1 ? 1 : 2);
      chk("tie grant", gnt_log[i], (i % 2));
      chk("tie result", resp_result, (i % 2 == 0) ? 32'd7 : 32'h30);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    step();

    // Backpressure: port 1 holds its result while port 0 waits.
    do_reset();
    resp0_ready = 1'b1; resp1_ready = 1'b0;
    issue(1'b1, 3'b110, 32'h0F, 32'hF0);
    req0_opcode = 3'b000; req0_left = 1; req0_right = 2; req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp req0_ready", req0_ready, 1'b0);
      chk("bp result", resp_result, 32'hFF);
    end
    resp1_ready = 1'b1;
    #1;
    chk("bp release req0_ready", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    chk("bp new result", resp_result, 32'd3);
    step();
    step();

    // Reset while a result is held: dropped, then the next tie goes to port 0.
    resp0_ready = 1'b0;
    issue(1'b0, 3'b000, 32'd1, 32'd1);
    step();
    chk("pre-reset resp0_valid", resp0_valid, 1'b1);
    do_reset();
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    step();
    chk("post-reset tie grant", g0, 1'b1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    step();

    // Counter wrap: 65536 completions return op_count to 0.
    do_reset();
    resp0_ready = 1'b1;
    req0_opcode = 3'b000; req0_left = 1; req0_right = 1; req0_valid = 1'b1;
    for (int i = 0; i < 65536; i++) step();
    req0_valid = 1'b0;
    chk("wrap pre", op_count, 16'hFFFF);
    step();
    chk("wrap zero", op_count, 16'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
